// File: rtl/poly_synth_core_pkg.sv
// Shared types, tuning table and helpers for the polyphonic keypad synth.
package poly_synth_core_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        SILENT = 2'd3
    } wave_e;

    localparam int unsigned INCR_BITS = 18;
    localparam int unsigned KEY_W     = 4;

    // Phase increments for a chromatic scale from C4, 10 MHz clock, 256-clk sample period:
    // round(f * 2^18 / 39062.5).
    localparam logic [INCR_BITS-1:0] KEY_INCR [16] = '{
        18'd1756, 18'd1860, 18'd1971, 18'd2088,
        18'd2212, 18'd2344, 18'd2483, 18'd2631,
        18'd2787, 18'd2953, 18'd3128, 18'd3314,
        18'd3511, 18'd3720, 18'd3941, 18'd4176
    };

    // Bit width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/poly_synth_core_if.sv
// Control and audio signals between the GPIO wrapper and the synth core.
interface poly_synth_core_if #(
    parameter int unsigned NUM_KEYS   = 15,
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PWM_BITS   = 8
);
    logic                  en;
    logic [NUM_KEYS-1:0]   keypad_i;
    logic [1:0]            wave_sel_i;
    logic                  pwm_o;
    logic [PWM_BITS-1:0]   sample_o;
    logic [NUM_VOICES-1:0] voice_active_o;

    modport master (
        output en, keypad_i, wave_sel_i,
        input  pwm_o, sample_o, voice_active_o
    );

    modport slave (
        input  en, keypad_i, wave_sel_i,
        output pwm_o, sample_o, voice_active_o
    );
endinterface

// File: rtl/poly_synth_core_voice.sv
// One oscillator: phase accumulator stepped once per sample, plus waveform shaping.
module poly_synth_core_voice
    import poly_synth_core_pkg::*;
#(
    parameter int unsigned ACC_BITS = 18,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 active,
    input  logic                 clr,
    input  logic                 tick,
    input  logic [INCR_BITS-1:0] incr,
    input  wave_e                wave,
    output logic [PWM_BITS-1:0]  sample
);

    logic [ACC_BITS-1:0] phase_q;
    logic [ACC_BITS-1:0] step;
    logic [PWM_BITS-1:0] t_bits;
    logic [PWM_BITS-1:0] u_bits;
    logic [PWM_BITS-1:0] wave_val;

    // Table is tuned for an 18-bit accumulator; wider accumulators scale the step up.
    assign step   = ACC_BITS'(incr) << (ACC_BITS - INCR_BITS);
    assign t_bits = phase_q[ACC_BITS-1 -: PWM_BITS];
    assign u_bits = phase_q[ACC_BITS-2 -: PWM_BITS];

    // Phase accumulator: cleared on free/disable, wraps silently.
    always_ff @(posedge clk) begin
        if (!n_rst || clr) begin
            phase_q <= '0;
        end else if (active && tick) begin
            phase_q <= phase_q + step;
        end
    end

    // Waveform select; an idle voice contributes nothing to the mix.
    always_comb begin
        wave_val = '0;
        unique case (wave)
            SQUARE: wave_val = phase_q[ACC_BITS-1] ? '1 : '0;
            SAW:    wave_val = t_bits;
            TRI:    wave_val = phase_q[ACC_BITS-1] ? ~u_bits : u_bits;
            SILENT: wave_val = '0;
        endcase
        sample = active ? wave_val : '0;
    end

endmodule

// File: rtl/poly_synth_core.sv
// Polyphonic keypad synth: synchroniser, debouncer, voice allocator, mixer and PWM output.
module poly_synth_core
    import poly_synth_core_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 15,
    parameter int unsigned NUM_VOICES      = 4,
    parameter int unsigned ACC_BITS        = 18,
    parameter int unsigned PWM_BITS        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input logic              clk,
    input logic              n_rst,
    poly_synth_core_if.slave bus
);

    localparam int unsigned VIDX_W = clog2_min1(NUM_VOICES);
    localparam int unsigned SHIFT  = $clog2(NUM_VOICES);
    localparam int unsigned SUM_W  = PWM_BITS + clog2_min1(NUM_VOICES);
    localparam int unsigned DB_W   = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Input path
    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] key_samp_q, key_db_q, key_db_d, stable;
    logic [DB_W-1:0]     db_cnt_q;
    logic                db_tick;

    // Allocator
    logic [NUM_KEYS-1:0]   held_q, held_d, rel, prs;
    logic [NUM_VOICES-1:0] voice_active_q, active_d, free_now, voice_clr;
    logic [KEY_W-1:0]      voice_key_q [NUM_VOICES];
    logic [KEY_W-1:0]      key_d [NUM_VOICES];
    logic [KEY_W-1:0]      rel_key, prs_key;
    logic [VIDX_W-1:0]     free_v, owner_v;
    logic                  rel_valid, prs_valid, free_valid, owner_valid;

    // Voices, mixer, PWM
    wave_e               wave;
    logic [PWM_BITS-1:0] voice_sample [NUM_VOICES];
    logic [SUM_W-1:0]    mix_sum;
    logic [PWM_BITS-1:0] mix_out;
    logic [PWM_BITS-1:0] pwm_cnt_q, sample_q;
    logic                pwm_q, sample_tick;

    assign db_tick = (db_cnt_q == DB_LAST);
    // A key level is accepted only when two consecutive ticks agree.
    assign stable   = ~(key_samp_q ^ sync2_q);
    assign key_db_d = (sync2_q & stable) | (key_db_q & ~stable);

    // Synchroniser and debouncer keep running while the block is disabled.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            key_samp_q <= '0;
            key_db_q   <= '0;
            db_cnt_q   <= '0;
        end else begin
            sync1_q <= bus.keypad_i;
            sync2_q <= sync1_q;
            if (db_tick) begin
                db_cnt_q   <= '0;
                key_samp_q <= sync2_q;
                key_db_q   <= key_db_d;
            end else begin
                db_cnt_q <= db_cnt_q + DB_W'(1);
            end
        end
    end

    // One allocation event per clk: lowest released key first, else lowest pressed key.
    always_comb begin
        rel         = held_q & ~key_db_q;
        prs         = key_db_q & ~held_q;
        rel_valid   = 1'b0;
        prs_valid   = 1'b0;
        free_valid  = 1'b0;
        owner_valid = 1'b0;
        rel_key     = '0;
        prs_key     = '0;
        free_v      = '0;
        owner_v     = '0;
        held_d      = held_q;
        active_d    = voice_active_q;
        key_d       = voice_key_q;
        free_now    = '0;
        // Scan downwards so the lowest index wins.
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (rel[k]) begin
                rel_valid = 1'b1;
                rel_key   = KEY_W'(k);
            end
            if (prs[k]) begin
                prs_valid = 1'b1;
                prs_key   = KEY_W'(k);
            end
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active_q[v]) begin
                free_valid = 1'b1;
                free_v     = VIDX_W'(v);
            end
            if (voice_active_q[v] && (voice_key_q[v] == rel_key)) begin
                owner_valid = 1'b1;
                owner_v     = VIDX_W'(v);
            end
        end
        if (rel_valid) begin
            held_d[rel_key] = 1'b0;
            if (owner_valid) begin
                active_d[owner_v] = 1'b0;
                free_now[owner_v] = 1'b1;
            end
        end else if (prs_valid && free_valid) begin
            // Without a free voice the press simply stays pending.
            held_d[prs_key]  = 1'b1;
            active_d[free_v] = 1'b1;
            key_d[free_v]    = prs_key;
        end
    end

    // Allocator state; disabling drops every voice so held keys re-allocate on enable.
    always_ff @(posedge clk) begin
        if (!n_rst || !bus.en) begin
            held_q         <= '0;
            voice_active_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                voice_key_q[v] <= '0;
            end
        end else begin
            held_q         <= held_d;
            voice_active_q <= active_d;
            voice_key_q    <= key_d;
        end
    end

    assign wave        = wave_e'(bus.wave_sel_i);
    assign sample_tick = (pwm_cnt_q == '1);
    assign voice_clr   = free_now | {NUM_VOICES{~bus.en}};

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        poly_synth_core_voice #(
            .ACC_BITS (ACC_BITS),
            .PWM_BITS (PWM_BITS)
        ) u_voice (
            .clk    (clk),
            .n_rst  (n_rst),
            .active (voice_active_q[v]),
            .clr    (voice_clr[v]),
            .tick   (sample_tick),
            .incr   (KEY_INCR[voice_key_q[v]]),
            .wave   (wave),
            .sample (voice_sample[v])
        );
    end

    // Mixer: plain sum scaled by voice count, truncated.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            mix_sum = mix_sum + SUM_W'(voice_sample[v]);
        end
        mix_out = PWM_BITS'(mix_sum >> SHIFT);
    end

    // PWM counter, sample register and registered comparator output.
    always_ff @(posedge clk) begin
        if (!n_rst || !bus.en) begin
            pwm_cnt_q <= '0;
            sample_q  <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            pwm_q     <= (pwm_cnt_q < sample_q);
            if (sample_tick) begin
                sample_q <= mix_out;
            end
        end
    end

    assign bus.pwm_o          = pwm_q;
    assign bus.sample_o       = sample_q;
    assign bus.voice_active_o = voice_active_q;

endmodule

// File: tb/tb_poly_synth_core.sv
// Directed bench for poly_synth_core with a small single-voice sample/PWM model.
module tb_poly_synth_core;

    localparam int unsigned NK = 15;
    localparam int unsigned NV = 4;
    localparam int unsigned PB = 8;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    poly_synth_core_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .PWM_BITS(PB)) bus ();

    poly_synth_core #(
        .NUM_KEYS        (NK),
        .NUM_VOICES      (NV),
        .ACC_BITS        (18),
        .PWM_BITS        (PB),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of voice 0 alone: phase, PWM counter, sample and PWM bit.
    int unsigned m_cnt = 0, m_sample = 0, m_pwm = 0, m_phase = 0, m_incr = 0;
    logic [NV-1:0] act_prev = '0;
    bit track = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned wave_val(input int unsigned ph, input logic [1:0] sel);
        int unsigned u;
        u = (ph / 512) % 256;
        case (sel)
            2'd0:    return (ph >= 131072) ? 255 : 0;
            2'd1:    return ph / 1024;
            2'd2:    return (ph >= 131072) ? 255 - u : u;
            default: return 0;
        endcase
    endfunction

    // Advance one clock, update the model for that edge, compare if tracking.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (!n_rst || !bus.en) begin
            m_cnt = 0; m_sample = 0; m_pwm = 0; m_phase = 0;
        end else begin
            m_pwm = (m_cnt < m_sample) ? 1 : 0;
            if (m_cnt == 255) begin
                if (act_prev[0]) begin
                    m_sample = wave_val(m_phase, bus.wave_sel_i) / 4;
                    m_phase  = (m_phase + m_incr) % 262144;
                end else begin
                    m_sample = 0;
                end
            end
            if (!act_prev[0]) m_phase = 0;
            m_cnt = (m_cnt + 1) % 256;
        end
        if (track) begin
            check_eq("sample", 32'(bus.sample_o), m_sample);
            check_eq("pwm", 32'(bus.pwm_o), m_pwm);
        end
        act_prev = bus.voice_active_o;
    endtask

    task automatic wait_va(input string tag, input logic [NV-1:0] exp, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            cycle();
            if (bus.voice_active_o == exp) break;
        end
        check_eq(tag, 32'(bus.voice_active_o), 32'(exp));
    endtask

    initial begin
        bit seen;
        bit xs;
        logic [PB-1:0] prev_s;

        n_rst          = 1'b0;
        bus.en         = 1'b1;
        bus.keypad_i   = '1;
        bus.wave_sel_i = 2'd0;

        // 1. Reset with every key down
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("rst_pwm", 32'(bus.pwm_o), 0);
            check_eq("rst_sample", 32'(bus.sample_o), 0);
            check_eq("rst_va", 32'(bus.voice_active_o), 0);
        end
        n_rst        = 1'b1;
        bus.keypad_i = '0;
        track        = 1'b1;

        // 2. Single square note on key 3
        m_incr = 2088;
        bus.keypad_i[3] = 1'b1;
        wait_va("press_k3", 4'b0001, 14);
        seen = 1'b0;
        for (int i = 0; i < 70 * 256; i++) begin
            cycle();
            if (bus.sample_o == 8'd63) seen = 1'b1;
        end
        check_eq("square_high_seen", 32'(seen), 1);
        bus.keypad_i[3] = 1'b0;
        wait_va("rel_k3", 4'b0000, 14);
        repeat (300) cycle();
        check_eq("rel_sample_zero", 32'(bus.sample_o), 0);

        // 3. Five keys at once, four voices
        track = 1'b0;
        bus.keypad_i = 15'h001F;
        wait_va("k0_v0", 4'b0001, 14);
        cycle(); check_eq("k1_v1", 32'(bus.voice_active_o), 32'b0011);
        cycle(); check_eq("k2_v2", 32'(bus.voice_active_o), 32'b0111);
        cycle(); check_eq("k3_v3", 32'(bus.voice_active_o), 32'b1111);
        repeat (5) cycle();
        check_eq("k4_pending", 32'(bus.voice_active_o), 32'b1111);
        bus.keypad_i = 15'h001D;
        wait_va("rel_k1_v1", 4'b1101, 14);
        cycle(); check_eq("k4_to_v1", 32'(bus.voice_active_o), 32'b1111);
        bus.keypad_i = '0;
        wait_va("all_rel", 4'b0000, 24);

        // 4. Short pulse and glitches must not register
        seen = 1'b0;
        bus.keypad_i[2] = 1'b1;
        repeat (3) begin cycle(); seen |= |bus.voice_active_o; end
        bus.keypad_i[2] = 1'b0;
        repeat (3) begin
            bus.keypad_i[5] = 1'b1;
            repeat (2) begin cycle(); seen |= |bus.voice_active_o; end
            bus.keypad_i[5] = 1'b0;
            repeat (5) begin cycle(); seen |= |bus.voice_active_o; end
        end
        repeat (20) begin cycle(); seen |= |bus.voice_active_o; end
        check_eq("glitch_ignored", 32'(seen), 0);
        repeat (300) cycle();
        track = 1'b1;

        // 5. Saw on key 14 through a phase wrap, then triangle and silent
        bus.wave_sel_i = 2'd1;
        m_incr = 3941;
        bus.keypad_i[14] = 1'b1;
        wait_va("press_k14", 4'b0001, 14);
        seen = 1'b0; xs = 1'b0; prev_s = bus.sample_o;
        for (int i = 0; i < 75 * 256; i++) begin
            cycle();
            if (bus.sample_o < prev_s) seen = 1'b1;
            if ($isunknown(bus.sample_o)) xs = 1'b1;
            prev_s = bus.sample_o;
        end
        check_eq("saw_wrap", 32'(seen), 1);
        check_eq("saw_no_x", 32'(xs), 0);
        bus.wave_sel_i = 2'd2;
        repeat (20 * 256) cycle();
        bus.wave_sel_i = 2'd3;
        repeat (2 * 256) cycle();
        check_eq("silent", 32'(bus.sample_o), 0);

        // 6. One-clock disable mid-note, key still held
        bus.wave_sel_i = 2'd0;
        bus.en = 1'b0;
        cycle();
        check_eq("dis_va", 32'(bus.voice_active_o), 0);
        check_eq("dis_pwm", 32'(bus.pwm_o), 0);
        check_eq("dis_sample", 32'(bus.sample_o), 0);
        bus.en = 1'b1;
        cycle();
        check_eq("realloc", 32'(bus.voice_active_o), 32'b0001);
        repeat (600) cycle();
        bus.keypad_i = '0;
        wait_va("final_rel", 4'b0000, 14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
